// File: rtl/inc_arbiter_pkg.sv
// Shared types and sizing helpers for the incrementer arbiter.
package inc_arbiter_pkg;

  // Output register occupancy: EMPTY holds no response, FULL holds one.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int default_nreq = 4;
  localparam int default_idw  = idx_width(default_nreq);

endpackage

// File: rtl/IncC.sv
// Combinational incrementer: {co_o, z_o} = a_i + ci_i.
// Bit i receives a carry when ci_i is set and all lower operand bits are one,
// so the core of the block is a prefix-AND over a_i. The speed parameter
// selects how that prefix is built: 0 ripple, 1 Brent-Kung, 2 Sklansky.
module IncC #(
  parameter int width = 8,
  parameter int speed = 2
) (
  input  logic [width-1:0] a_i,
  input  logic             ci_i,
  output logic [width-1:0] z_o,
  output logic             co_o
);

  localparam int lg = (width > 1) ? $clog2(width) : 1;

  // p[i] ends up as the AND of a_i[i:0]
  logic [width-1:0] p;

  // Prefix-AND network, shape chosen at elaboration time
  always_comb begin
    // NOTE: blocking assignments here build a chain of combinational stages
    // inside one process; each loop iteration sees the previous stage's value.
    p = a_i;
    if (speed == 0) begin
      for (int i = 1; i < width; i++) begin
        p[i] = p[i] & p[i-1];
      end
    end else if (speed == 1) begin
      // Up-sweep: build power-of-two spans ending at i = k*2^(l+1) - 1
      for (int l = 0; l < lg; l++) begin
        for (int i = (1 << (l + 1)) - 1; i < width; i += (1 << (l + 1))) begin
          p[i] = p[i] & p[i - (1 << l)];
        end
      end
      // Down-sweep: fill the remaining positions from the completed spans
      for (int l = lg - 2; l >= 0; l--) begin
        for (int i = 3 * (1 << l) - 1; i < width; i += (1 << (l + 1))) begin
          p[i] = p[i] & p[i - (1 << l)];
        end
      end
    end else begin
      // At level l every index with bit l set pulls in the span just below
      // its aligned 2^l block; that source index has bit l clear, so the
      // in-place update never reads a value already changed at this level.
      for (int l = 0; l < lg; l++) begin
        for (int i = 1; i < width; i++) begin
          if (((i >> l) & 1) == 1) begin
            p[i] = p[i] & p[((i >> l) << l) - 1];
          end
        end
      end
    end
  end

  // Sum bits and carry-out from the prefix terms
  always_comb begin
    z_o    = '0;
    z_o[0] = a_i[0] ^ ci_i;
    for (int i = 1; i < width; i++) begin
      z_o[i] = a_i[i] ^ (ci_i & p[i-1]);
    end
    co_o = ci_i & p[width-1];
  end

endmodule

// File: rtl/inc_arbiter.sv
// Round-robin arbiter in front of one shared incrementer. One request is
// accepted per cycle when the single-entry output register can take it; the
// result is registered and presented with a valid/ready handshake.
module inc_arbiter
  import inc_arbiter_pkg::*;
#(
  parameter int width = 8,
  parameter int speed = 2,
  parameter int nreq  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [nreq-1:0]              req_valid_i,
  output logic [nreq-1:0]              req_ready_o,
  input  logic [nreq*width-1:0]        req_a_i,
  input  logic [nreq-1:0]              req_ci_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [width-1:0]             rsp_z_o,
  output logic                         rsp_co_o,
  output logic [idx_width(nreq)-1:0]   rsp_id_o
);

  localparam int idw = idx_width(nreq);

  out_state_e       state_q, state_d;
  logic [idw-1:0]   ptr_q;
  logic [width-1:0] z_q;
  logic             co_q;
  logic [idw-1:0]   id_q;

  logic             slot_open;
  logic             gnt_found;
  logic [idw-1:0]   gnt_idx;
  logic             accept;
  logic [width-1:0] sel_a;
  logic             sel_ci;
  logic [width-1:0] inc_z;
  logic             inc_co;

  // The slot can take a new result if it is empty or being drained this cycle
  assign slot_open = (state_q == EMPTY) || rsp_ready_i;

  // Round-robin search: first valid requester at or after ptr_q, wrapping
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < nreq; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idw'(idx);
      end
    end
  end

  // Reset is folded in so no requester sees a ready while the block is held
  assign accept = rst_ni && slot_open && gnt_found;

  // One-hot ready for the winner only
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[gnt_idx] = 1'b1;
  end

  // Steer the winner's operand into the shared incrementer
  always_comb begin
    sel_a  = req_a_i[int'(gnt_idx)*width +: width];
    sel_ci = req_ci_i[gnt_idx];
  end

  IncC #(
    .width (width),
    .speed (speed)
  ) u_inc (
    .a_i  (sel_a),
    .ci_i (sel_ci),
    .z_o  (inc_z),
    .co_o (inc_co)
  );

  // Output occupancy: fill on accept, empty on drain without a refill
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && rsp_ready_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State, pointer and response registers; data only loads on accept so a
  // stalled response stays stable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: every flop here is a real control/data register (no memory
    // arrays), so all of them are cleared by the asynchronous reset.
    if (!rst_ni) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      z_q     <= '0;
      co_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        z_q   <= inc_z;
        co_q  <= inc_co;
        id_q  <= gnt_idx;
        ptr_q <= (gnt_idx == idw'(nreq - 1)) ? '0 : gnt_idx + idw'(1);
      end
    end
  end

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_z_o     = z_q;
  assign rsp_co_o    = co_q;
  assign rsp_id_o    = id_q;

endmodule

// File: tb/tb_inc_arbiter.sv
// Bench for inc_arbiter: directed vector table, reset corner case, and a
// random phase with a reference model plus two extra width/speed variants.
module tb_inc_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // Main instance: width 8, nreq 4, Sklansky
  logic [3:0]  req_valid, req_ready, req_ci;
  logic [31:0] req_a;
  logic        rsp_valid, rsp_ready, rsp_co;
  logic [7:0]  rsp_z;
  logic [1:0]  rsp_id;

  inc_arbiter #(.width(8), .speed(2), .nreq(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_ci_i(req_ci),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_z_o(rsp_z), .rsp_co_o(rsp_co), .rsp_id_o(rsp_id)
  );

  // Variant: width 13, nreq 3, Brent-Kung
  logic [2:0]  v13, r13, ci13;
  logic [38:0] a13;
  logic        vo13, co13;
  logic [12:0] z13;
  logic [1:0]  id13;
  logic        rr_one = 1'b1;

  inc_arbiter #(.width(13), .speed(1), .nreq(3)) dut13 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(v13), .req_ready_o(r13),
    .req_a_i(a13), .req_ci_i(ci13),
    .rsp_valid_o(vo13), .rsp_ready_i(rr_one),
    .rsp_z_o(z13), .rsp_co_o(co13), .rsp_id_o(id13)
  );

  // Variant: width 1, nreq 2, ripple
  logic [1:0] v1, r1, a1, ci1;
  logic       vo1, co1;
  logic [0:0] z1;
  logic [0:0] id1;

  inc_arbiter #(.width(1), .speed(0), .nreq(2)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(v1), .req_ready_o(r1),
    .req_a_i(a1), .req_ci_i(ci1),
    .rsp_valid_o(vo1), .rsp_ready_i(rr_one),
    .rsp_z_o(z1), .rsp_co_o(co1), .rsp_id_o(id1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [3:0]  ci;
    logic        rr;
    logic [3:0]  e_ready;
    logic        e_valid;
    logic [7:0]  e_z;
    logic        e_co;
    logic [1:0]  e_id;
  } vec_t;

  vec_t vecs[16];

  // Round-robin pick for the model; -1 when nobody is valid
  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int idx = (p + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Model state for the random phase
  logic       m_full;
  logic [7:0] m_z;
  logic       m_co;
  logic [1:0] m_id;
  int         m_ptr;
  int         wait_cnt[4];
  int         e_id13, e_id1;
  logic [38:0] p_a13;
  logic [2:0]  p_ci13;
  logic [1:0]  p_a1, p_ci1;

  initial begin
    req_valid = '0; req_a = '0; req_ci = '0; rsp_ready = 1'b0;
    v13 = '0; a13 = '0; ci13 = '0;
    v1 = '0; a1 = '0; ci1 = '0;

    // Hand-computed vectors, applied in order from reset (ptr=0, EMPTY)
    //           valid    a             ci      rr    ready    vld  z      co    id
    vecs[0]  = '{4'b0001, 32'h000000FF, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h00, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 32'h30201000, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 1'b0, 2'd1};
    vecs[2]  = '{4'b1111, 32'h30201000, 4'b1010, 1'b1, 4'b0100, 1'b1, 8'h20, 1'b0, 2'd2};
    vecs[3]  = '{4'b1111, 32'h30201000, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h31, 1'b0, 2'd3};
    vecs[4]  = '{4'b1111, 32'h30201000, 4'b1010, 1'b1, 4'b0001, 1'b1, 8'h00, 1'b0, 2'd0};
    vecs[5]  = '{4'b1111, 32'h30201000, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 1'b0, 2'd1};
    vecs[6]  = '{4'b0100, 32'h00400000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h41, 1'b0, 2'd2};
    vecs[7]  = '{4'b1111, 32'h30201000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h41, 1'b0, 2'd2};
    vecs[8]  = '{4'b1111, 32'h30201000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h41, 1'b0, 2'd2};
    vecs[9]  = '{4'b1111, 32'h30201000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h41, 1'b0, 2'd2};
    vecs[10] = '{4'b1111, 32'h30201000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h41, 1'b0, 2'd2};
    vecs[11] = '{4'b1111, 32'h30201000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h41, 1'b0, 2'd2};
    vecs[12] = '{4'b1111, 32'h30201000, 4'b0000, 1'b1, 4'b1000, 1'b1, 8'h30, 1'b0, 2'd3};
    vecs[13] = '{4'b1001, 32'h30201000, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'h00, 1'b0, 2'd0};
    vecs[14] = '{4'b0000, 32'h30201000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[15] = '{4'b0100, 32'h00FF0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'hFF, 1'b0, 2'd2};

    // Reset state
    #2;
    check("rst.valid", rsp_valid, 0);
    check("rst.z", rsp_z, 0);
    check("rst.co", rsp_co, 0);
    check("rst.id", rsp_id, 0);
    check("rst.ready", req_ready, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      req_valid = vecs[i].valid; req_a = vecs[i].a;
      req_ci = vecs[i].ci; rsp_ready = vecs[i].rr;
      @(negedge clk_i);
      check($sformatf("v%0d.ready", i), req_ready, vecs[i].e_ready);
      @(posedge clk_i); #1;
      check($sformatf("v%0d.valid", i), rsp_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d.z", i), rsp_z, vecs[i].e_z);
        check($sformatf("v%0d.co", i), rsp_co, vecs[i].e_co);
        check($sformatf("v%0d.id", i), rsp_id, vecs[i].e_id);
      end
    end

    // Fill with 0x7F (ptr=3 wraps to requester 0), then reset mid-cycle
    req_valid = 4'b0001; req_a = 32'h0000007E; req_ci = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk_i);
    check("pre_rst.ready", req_ready, 4'b0001);
    @(posedge clk_i); #1;
    check("pre_rst.z", rsp_z, 8'h7F);
    check("pre_rst.valid", rsp_valid, 1);
    rsp_ready = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mid_rst.valid", rsp_valid, 0);
    check("mid_rst.z", rsp_z, 0);
    check("mid_rst.id", rsp_id, 0);
    check("mid_rst.ready", req_ready, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    req_valid = 4'b0110; req_a = 32'h00050900; req_ci = 4'b0000; rsp_ready = 1'b1;
    @(negedge clk_i);
    check("post_rst.ready", req_ready, 4'b0010);
    @(posedge clk_i); #1;
    check("post_rst.id", rsp_id, 1);
    check("post_rst.z", rsp_z, 8'h09);
    check("post_rst.valid", rsp_valid, 1);

    // Random phase; model starts from the state just established
    m_full = 1'b1; m_z = 8'h09; m_co = 1'b0; m_id = 2'd1; m_ptr = 2;
    for (int r = 0; r < 4; r++) wait_cnt[r] = 0;
    e_id13 = 0; e_id1 = 0;
    req_valid = '0;
    v13 = 3'b111; v1 = 2'b11;
    for (int cyc = 0; cyc < 300; cyc++) begin
      int g;
      logic open;
      logic [3:0] e_ready;
      logic [8:0] sum;
      logic [13:0] s13;
      logic [1:0]  s1;
      req_valid = req_valid | 4'($urandom_range(15));
      for (int r = 0; r < 4; r++) begin
        req_a[r*8 +: 8] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      end
      req_ci = 4'($urandom_range(15));
      rsp_ready = ($urandom_range(3) != 0);
      for (int r = 0; r < 3; r++) begin
        a13[r*13 +: 13] = ($urandom_range(3) == 0) ? 13'h1FFF : 13'($urandom);
      end
      ci13 = 3'($urandom_range(7));
      a1 = 2'($urandom_range(3)); ci1 = 2'($urandom_range(3));

      @(negedge clk_i);
      open = !m_full || rsp_ready;
      g = open ? rr_pick(req_valid, m_ptr) : -1;
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      check($sformatf("rnd%0d.ready", cyc), req_ready, e_ready);
      check($sformatf("rnd%0d.ready13", cyc), r13, 3'b001 << e_id13);
      p_a13 = a13; p_ci13 = ci13; p_a1 = a1; p_ci1 = ci1;
      if (g >= 0) begin
        check($sformatf("rnd%0d.fair", cyc), wait_cnt[g] < 4, 1);
        for (int r = 0; r < 4; r++) begin
          if (r != g && req_valid[r]) wait_cnt[r]++;
        end
        wait_cnt[g] = 0;
        sum = {1'b0, req_a[g*8 +: 8]} + 9'(req_ci[g]);
        m_z = sum[7:0]; m_co = sum[8]; m_id = 2'(g); m_full = 1'b1;
        m_ptr = (g + 1) % 4;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end

      @(posedge clk_i); #1;
      check($sformatf("rnd%0d.valid", cyc), rsp_valid, m_full);
      if (m_full) begin
        check($sformatf("rnd%0d.sum", cyc), {rsp_co, rsp_z, rsp_id}, {m_co, m_z, m_id});
      end
      s13 = {1'b0, p_a13[e_id13*13 +: 13]} + 14'(p_ci13[e_id13]);
      check($sformatf("rnd%0d.w13", cyc), {vo13, id13, co13, z13}, {1'b1, 2'(e_id13), s13});
      s1 = {1'b0, p_a1[e_id1]} + 2'(p_ci1[e_id1]);
      check($sformatf("rnd%0d.w1", cyc), {vo1, id1, co1, z1}, {1'b1, 1'(e_id1), s1});
      e_id13 = (e_id13 + 1) % 3;
      e_id1 = (e_id1 + 1) % 2;
      if (g >= 0) req_valid[g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inc_arbiter.md
INC_ARBITER -- requirements
Module: inc_arbiter

Interface
REQ-001 Parameter width, default 8: operand and result width in bits, ≥ 1.
REQ-002 Parameter speed, default 2: prefix-structure selector passed to the incrementer (0 serial, 1 Brent-Kung, 2 Sklansky).
REQ-003 Parameter nreq, default 4: number of requesters, ≥ 2.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  input  nreq  per-requester request valid.
REQ-007 req_ready_o  output  nreq  per-requester accept; one-hot or zero.
REQ-008 req_a_i  input  nreq*width  operands; requester r occupies bits [r*width +: width].
REQ-009 req_ci_i  input  nreq  per-requester carry-in.
REQ-010 rsp_valid_o  output  1  response valid.
REQ-011 rsp_ready_i  input  1  response consumer ready.
REQ-012 rsp_z_o  output  width  registered sum Z.
REQ-013 rsp_co_o  output  1  registered carry-out.
REQ-014 rsp_id_o  output  max(1,$clog2(nreq))  index of the requester that produced the response.

Function
REQ-015 {rsp_co_o, rsp_z_o} SHALL equal req_a_i[g] + req_ci_i[g], modulo 2^(width+1), where g is the granted requester.
REQ-016 The block SHALL use a single incrementer instance shared by all requesters; at most one request SHALL be accepted per cycle.
REQ-017 A transfer SHALL occur on requester r when req_valid_i[r] and req_ready_o[r] are both high; a response transfer SHALL occur when rsp_valid_o and rsp_ready_i are both high.
REQ-018 The output slot SHALL be open when rsp_valid_o is low or rsp_ready_i is high. While the slot is closed, req_ready_o SHALL be all-zero.
REQ-019 req_ready_o SHALL be asserted only for the round-robin winner. Search order starts at pointer ptr and ascends with wrap from nreq-1 to 0. req_ready_o SHALL depend combinationally on req_valid_i and rsp_ready_i.
REQ-020 After an accepted request from requester g, ptr SHALL become (g+1) mod nreq. With no acceptance, ptr SHALL hold.
REQ-021 Latency: an accepted request SHALL appear on rsp_*_o in the next cycle with rsp_valid_o high, giving one result per cycle at full throughput.
REQ-022 Draining the response and accepting a new request in the same cycle SHALL load the new result with no bubble.
REQ-023 While rsp_valid_o is high and rsp_ready_i is low, rsp_z_o, rsp_co_o and rsp_id_o SHALL remain stable.
REQ-024 A requester that holds req_valid_i high SHALL be granted within nreq accepted transfers.
REQ-025 Output state: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1).
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain without accept.
  - FULL to FULL on drain with accept, or on stall.

Reset
REQ-026 While rst_ni is low, these outputs SHALL be 0: rsp_valid_o, rsp_z_o, rsp_co_o, rsp_id_o, and ptr; req_ready_o SHALL then be all-zero.
REQ-027 A reset asserted mid-operation SHALL discard the pending response immediately, with no partial transfer. The first grant after reset SHALL go to the lowest-indexed valid requester.

Structure
REQ-028 The requester-index width constant and the output-state enum (EMPTY, FULL) SHALL reside in a shared package, inc_arbiter_pkg.
REQ-029 The sum SHALL be computed by one instance of the existing incrementer module IncC, parameterised (width, speed). The round-robin selector SHALL be inline; no other sub-module.
REQ-030 The incrementer path SHALL be combinational, feeding the output register only.

Verification (width=8, nreq=4)
REQ-031 Only requester 0 valid, A=0xFF, CI=1, rsp_ready_i=1 -> next cycle rsp_valid_o=1, Z=0x00, CO=1, id=0.
REQ-032 All four valid continuously, rsp_ready_i=1 -> ids 0,1,2,3,0,1 on consecutive cycles, no bubbles.
REQ-033 Response Z=0x41 pending, rsp_ready_i=0 for 5 cycles -> Z, CO and id held, req_ready_o=0000. rsp_ready_i=1 -> the next grant is taken in the same cycle.
REQ-034 After a grant to requester 3, requesters 0 and 3 both valid -> requester 0 is granted (pointer wrap).
REQ-035 Reset pulsed while FULL (Z=0x7F) -> outputs 0 within the reset cycle. After release, requesters 2 and 1 valid -> requester 1 granted first.
REQ-036 Random stimulus for speed ∈ {0,1,2} and width ∈ {1,8,13} -> every response matches A+CI, and no requester waits more than nreq grants.
